// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage LC-3b pipeline: stage load enables,
// bubble injection, branch redirect sequencing and saturating perf counters.
module pipeline_ctrl #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 imem_resp,
   output logic                 imem_read,
   input  logic                 dmem_req,
   input  logic                 dmem_resp,
   input  logic                 de_valid,
   input  logic                 ex_valid,
   input  logic                 ex_is_load,
   input  logic [2:0]           ex_dest,
   input  logic                 de_use_sr1,
   input  logic                 de_use_sr2,
   input  logic [2:0]           de_sr1_id,
   input  logic [2:0]           de_sr2_id,
   input  logic                 br_taken,
   output logic                 load_pc,
   output logic                 load_if_de,
   output logic                 load_de_ex,
   output logic                 load_ex_mem,
   output logic                 load_mem_wb,
   output logic                 bubble_if_de,
   output logic                 bubble_de_ex,
   output logic                 bubble_ex_mem,
   output logic                 redirect_sel,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count
);

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t state;
   state_t state_next;
   logic   mstall;
   logic   lu;
   logic   fstall;
   logic   stall_inc;
   logic   flush_inc;

   assign mstall = dmem_req & ~dmem_resp;
   assign fstall = ~imem_resp;
   assign lu     = de_valid & ex_valid & ex_is_load &
                   ((de_use_sr1 & (de_sr1_id == ex_dest)) |
                    (de_use_sr2 & (de_sr2_id == ex_dest)));

   // Zero-latency control decode; reset overrides everything with a bubbled, frozen pipe.
   always_comb begin
      state_next    = state;
      imem_read     = 1'b0;
      load_pc       = 1'b0;
      load_if_de    = 1'b0;
      load_de_ex    = 1'b0;
      load_ex_mem   = 1'b0;
      load_mem_wb   = 1'b0;
      bubble_if_de  = 1'b0;
      bubble_de_ex  = 1'b0;
      bubble_ex_mem = 1'b0;
      redirect_sel  = 1'b0;
      flush_inc     = 1'b0;
      stall_inc     = 1'b0;
      if (reset) begin
         bubble_if_de  = 1'b1;
         bubble_de_ex  = 1'b1;
         bubble_ex_mem = 1'b1;
      end else begin
         case (state)
            INIT: begin
               load_if_de    = 1'b1;
               load_de_ex    = 1'b1;
               load_ex_mem   = 1'b1;
               load_mem_wb   = 1'b1;
               bubble_if_de  = 1'b1;
               bubble_de_ex  = 1'b1;
               bubble_ex_mem = 1'b1;
               state_next    = RUN;
            end
            RUN: begin
               imem_read = 1'b1;
               if (mstall) begin
                  // whole pipe frozen, a taken branch in MEM waits here too
               end else if (br_taken & ~fstall) begin
                  load_pc       = 1'b1;
                  load_if_de    = 1'b1;
                  load_de_ex    = 1'b1;
                  load_ex_mem   = 1'b1;
                  load_mem_wb   = 1'b1;
                  bubble_if_de  = 1'b1;
                  bubble_de_ex  = 1'b1;
                  bubble_ex_mem = 1'b1;
                  redirect_sel  = 1'b1;
                  flush_inc     = 1'b1;
               end else if (br_taken) begin
                  load_de_ex    = 1'b1;
                  load_ex_mem   = 1'b1;
                  load_mem_wb   = 1'b1;
                  bubble_de_ex  = 1'b1;
                  bubble_ex_mem = 1'b1;
                  flush_inc     = 1'b1;
                  state_next    = REDIRECT;
               end else if (lu) begin
                  load_de_ex   = 1'b1;
                  load_ex_mem  = 1'b1;
                  load_mem_wb  = 1'b1;
                  bubble_de_ex = 1'b1;
               end else if (fstall) begin
                  load_if_de   = 1'b1;
                  load_de_ex   = 1'b1;
                  load_ex_mem  = 1'b1;
                  load_mem_wb  = 1'b1;
                  bubble_if_de = 1'b1;
               end else begin
                  load_pc     = 1'b1;
                  load_if_de  = 1'b1;
                  load_de_ex  = 1'b1;
                  load_ex_mem = 1'b1;
                  load_mem_wb = 1'b1;
               end
            end
            REDIRECT: begin
               imem_read = 1'b1;
               if (!mstall) begin
                  // wrong-path fetch still outstanding; keep DE/EX killed
                  load_de_ex   = 1'b1;
                  bubble_de_ex = 1'b1;
                  load_ex_mem  = 1'b1;
                  load_mem_wb  = 1'b1;
                  if (imem_resp) begin
                     load_pc      = 1'b1;
                     redirect_sel = 1'b1;
                     load_if_de   = 1'b1;
                     bubble_if_de = 1'b1;
                     state_next   = RUN;
                  end
               end
            end
            default: state_next = INIT;
         endcase
         stall_inc = ((state == RUN) | (state == REDIRECT)) & ~load_pc;
      end
   end

   // State register and saturating performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state <= state_next;
         if (stall_inc && (stall_cycles != CNT_MAX))
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
         if (flush_inc && (flush_count != CNT_MAX))
            flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

endmodule
